branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Branch-resolution stage directly upstream of the program counter.
- Holds the compare flags written back by the ALU and decodes the current instruction's branch op.
- Looks up the relative jump offset in a programmable target table and drives the PC's jump-enable, equal/greater condition and target inputs.
- Sequences run/halt for the program and counts taken branches for debug.

Parameters:
- D, 8, width of jump target / PC offset.
- LW, 4, target-table index width (2^LW entries).
- CW, 8, taken-branch counter width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin program; aligned with the PC's start input.
- halt  in  1  program-complete strobe from the decoder.
- flag_we  in  1  load the ALU compare results into the flag register.
- alu_eq  in  1  ALU equal result.
- alu_gt  in  1  ALU greater-than result.
- br_op  in  2  00 none, 01 beq, 10 bgt, 11 jmp (unconditional).
- lut_idx  in  LW  target-table read index from the instruction field.
- lut_we  in  1  target-table write enable.
- lut_waddr  in  LW  target-table write address.
- lut_wdata  in  D  target-table write data (signed two's-complement offset).
- reljump_en  out  1  to PC: relative-jump enable.
- E  out  1  to PC: equal-path / unconditional take.
- G  out  1  to PC: greater-path take.
- target  out  D  to PC: relative offset.
- taken  out  1  branch taken this cycle (equals E|G).
- done  out  1  high in HALT.
- taken_cnt  out  CW  taken branches since the last start.

Behaviour:
- FSM states: IDLE, RUN, HALT. Reset state is IDLE.
- Transitions:
  - start in any state -> RUN.
  - RUN with halt=1 and start=0 -> HALT.
  - HALT holds until the next start.
  - start and halt in the same cycle: start wins, next state is RUN.
- Flag register eq_f/gt_f:
  - Loaded from alu_eq/alu_gt at posedge when flag_we=1.
  - Cleared by reset and by start; start beats flag_we in the same cycle.
  - A branch in the same cycle as flag_we uses the old registered flags.
- Outputs (combinational from state, flags and inputs; zero-latency so the PC acts at the same edge):
  - reljump_en = RUN & (br_op!=00).
  - E = RUN & ((br_op==01 & eq_f) | br_op==11).
  - G = RUN & (br_op==10 & gt_f).
  - taken = E | G.
  - target = lut[lut_idx] when reljump_en, else 0.
- Outside RUN (IDLE, HALT, or the start cycle itself, since state is not yet RUN): reljump_en=E=G=taken=0 and target=0.
- Target table:
  - 2^LW x D registers, all cleared to 0 by reset and not cleared by start.
  - Writes (lut_we) take effect at posedge and are allowed in any state.
  - A read and a write to the same index in the same cycle returns the old value.
- taken_cnt:
  - Increments at posedge when taken=1.
  - Saturates at 2^CW-1, no wrap.
  - Cleared by reset and start; start beats increment.
- done = (state==HALT).
- Reset mid-operation: asynchronous. All outputs are 0 immediately and held at 0 while reset is high, regardless of clk. The first start after reset deassertion begins RUN.

Test Plan:
- Reset check: assert reset mid-RUN with br_op=11 -> reljump_en, E, G, target, done and taken_cnt go to 0 without a clock edge; state IDLE.
- Table program: write lut[3]=0x05 and lut[7]=0xFB (-5); start; flag_we with eq=1, gt=0; beq idx 3 -> reljump_en=1, E=1, G=0, target=0x05. Next cycle bgt idx 7 -> reljump_en=1, E=0, G=0, target=0xFB, taken=0.
- Flag timing: flags 0/0, flag_we with gt=1 in the same cycle as bgt -> G=0 that cycle. bgt on the next cycle -> G=1, taken_cnt +1.
- Unconditional: flags cleared, jmp idx 0 with lut[0]=0x10 -> E=1, target=0x10. Repeat 300 cycles with CW=8 -> taken_cnt saturates at 255.
- Halt/start race: in RUN, halt=1 -> done=1 and br_op=11 gives reljump_en=0. Then start and halt together -> RUN, done=0, taken_cnt=0, flags=0.
- Table read-during-write: lut[2]=0x01; same-cycle write lut[2]=0x22 while beq idx 2 with eq_f=1 -> target=0x01 that cycle, 0x22 on the next.

Source files
------------

// File: rtl/branch_if.sv
// branch_if: decoder/ALU-side inputs and PC-side outputs of the branch-resolution stage
interface branch_if #(parameter int D = 8, parameter int LW = 4, parameter int CW = 8);
  logic start;
  logic halt;
  logic flag_we;
  logic alu_eq;
  logic alu_gt;
  logic [1:0] br_op;
  logic [LW-1:0] lut_idx;
  logic lut_we;
  logic [LW-1:0] lut_waddr;
  logic [D-1:0] lut_wdata;
  logic reljump_en;
  logic E;
  logic G;
  logic [D-1:0] target;
  logic taken;
  logic done;
  logic [CW-1:0] taken_cnt;
  modport master (
    output start, halt, flag_we, alu_eq, alu_gt, br_op, lut_idx, lut_we, lut_waddr, lut_wdata,
    input reljump_en, E, G, target, taken, done, taken_cnt
  );
  modport slave (
    input start, halt, flag_we, alu_eq, alu_gt, br_op, lut_idx, lut_we, lut_waddr, lut_wdata,
    output reljump_en, E, G, target, taken, done, taken_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves branches from registered ALU flags and a programmable offset table for the PC
module branch_ctrl #(
  parameter int D = 8,
  parameter int LW = 4,
  parameter int CW = 8
) (
  input logic clk,
  input logic reset,
  branch_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  logic [1:0] state;
  logic eq_f, gt_f;
  logic [D-1:0] lut [2**LW];
  logic [CW-1:0] cnt;
  logic run;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      eq_f <= 1'b0;
      gt_f <= 1'b0;
      cnt <= '0;
    end else begin
      state <= bus.start ? RUN : (state == RUN && bus.halt) ? HALT : state;
      eq_f <= bus.start ? 1'b0 : bus.flag_we ? bus.alu_eq : eq_f;
      gt_f <= bus.start ? 1'b0 : bus.flag_we ? bus.alu_gt : gt_f;
      cnt <= bus.start ? '0 : (bus.taken && cnt != '1) ? cnt + 1'b1 : cnt;
    end
  end
  // table survives start; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**LW; i++) lut[i] <= '0;
    end else if (bus.lut_we) begin
      lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end
  always_comb begin
    run = state == RUN;
    bus.reljump_en = run && bus.br_op != 2'b00;
    bus.E = run && ((bus.br_op == 2'b01 && eq_f) || bus.br_op == 2'b11);
    bus.G = run && bus.br_op == 2'b10 && gt_f;
    bus.taken = bus.E || bus.G;
    bus.target = bus.reljump_en ? lut[bus.lut_idx] : '0;
    bus.done = state == HALT;
    bus.taken_cnt = cnt;
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed checks of flags, table, FSM, counter saturation and async reset
module tb_branch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vecs = 0;
  int errs = 0;
  branch_if #(.D(8), .LW(4), .CW(8)) bus ();
  branch_ctrl #(.D(8), .LW(4), .CW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.lut_we = 1'b1;
    bus.lut_waddr = a;
    bus.lut_wdata = d;
    tick();
    bus.lut_we = 1'b0;
  endtask
  task automatic flags(input logic eq, input logic gt);
    bus.flag_we = 1'b1;
    bus.alu_eq = eq;
    bus.alu_gt = gt;
    tick();
    bus.flag_we = 1'b0;
  endtask
  initial begin
    bus.start = 0; bus.halt = 0; bus.flag_we = 0; bus.alu_eq = 0; bus.alu_gt = 0;
    bus.br_op = 2'b00; bus.lut_idx = '0; bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_done", bus.done, 0);
    chk("rst_cnt", bus.taken_cnt, 0);
    wr(4'd3, 8'h05);
    wr(4'd7, 8'hFB);
    wr(4'd0, 8'h10);
    wr(4'd2, 8'h01);
    bus.br_op = 2'b11; bus.lut_idx = 4'd3;
    #1;
    chk("idle_rel", bus.reljump_en, 0);
    chk("idle_tgt", bus.target, 0);
    bus.start = 1'b1;
    #1;
    chk("startcyc_E", bus.E, 0);
    chk("startcyc_taken", bus.taken, 0);
    tick();
    bus.start = 1'b0; bus.br_op = 2'b00;
    flags(1'b1, 1'b0);
    bus.br_op = 2'b01; bus.lut_idx = 4'd3;
    #1;
    chk("beq_rel", bus.reljump_en, 1);
    chk("beq_E", bus.E, 1);
    chk("beq_G", bus.G, 0);
    chk("beq_tgt", bus.target, 8'h05);
    chk("beq_taken", bus.taken, 1);
    tick();
    bus.br_op = 2'b10; bus.lut_idx = 4'd7;
    #1;
    chk("bgt_rel", bus.reljump_en, 1);
    chk("bgt_E", bus.E, 0);
    chk("bgt_G", bus.G, 0);
    chk("bgt_tgt", bus.target, 8'hFB);
    chk("bgt_taken", bus.taken, 0);
    chk("cnt_1", bus.taken_cnt, 1);
    tick();
    bus.br_op = 2'b00;
    flags(1'b0, 1'b0);
    bus.flag_we = 1'b1; bus.alu_gt = 1'b1; bus.br_op = 2'b10;
    #1;
    chk("flagwe_oldG", bus.G, 0);
    tick();
    bus.flag_we = 1'b0;
    #1;
    chk("flag_newG", bus.G, 1);
    tick();
    bus.br_op = 2'b00;
    #1;
    chk("cnt_2", bus.taken_cnt, 2);
    flags(1'b0, 1'b0);
    bus.br_op = 2'b11; bus.lut_idx = 4'd0;
    #1;
    chk("jmp_E", bus.E, 1);
    chk("jmp_tgt", bus.target, 8'h10);
    for (int i = 0; i < 300; i++) tick();
    chk("cnt_sat", bus.taken_cnt, 255);
    chk("sat_taken", bus.taken, 1);
    bus.br_op = 2'b00; bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    flags(1'b1, 1'b1);
    bus.br_op = 2'b11;
    #1;
    chk("halt_done", bus.done, 1);
    chk("halt_rel", bus.reljump_en, 0);
    chk("halt_E", bus.E, 0);
    chk("halt_cnt", bus.taken_cnt, 255);
    bus.br_op = 2'b00; bus.start = 1'b1; bus.halt = 1'b1;
    tick();
    bus.start = 1'b0; bus.halt = 1'b0;
    bus.br_op = 2'b01;
    #1;
    chk("race_done", bus.done, 0);
    chk("race_cnt", bus.taken_cnt, 0);
    chk("race_rel", bus.reljump_en, 1);
    chk("race_eqclr", bus.E, 0);
    bus.br_op = 2'b10;
    #1;
    chk("race_gtclr", bus.G, 0);
    bus.br_op = 2'b00;
    flags(1'b1, 1'b0);
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd2; bus.lut_wdata = 8'h22;
    bus.br_op = 2'b01; bus.lut_idx = 4'd2;
    #1;
    chk("rdw_old", bus.target, 8'h01);
    chk("rdw_E", bus.E, 1);
    tick();
    bus.lut_we = 1'b0;
    #1;
    chk("rdw_new", bus.target, 8'h22);
    tick();
    bus.br_op = 2'b11; bus.lut_idx = 4'd0;
    #1;
    chk("pre_rst_cnt", bus.taken_cnt, 2);
    chk("pre_rst_rel", bus.reljump_en, 1);
    reset = 1'b1;
    #1;
    chk("arst_rel", bus.reljump_en, 0);
    chk("arst_E", bus.E, 0);
    chk("arst_G", bus.G, 0);
    chk("arst_tgt", bus.target, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_cnt", bus.taken_cnt, 0);
    bus.start = 1'b1;
    tick();
    tick();
    chk("rsthold_rel", bus.reljump_en, 0);
    reset = 1'b0;
    tick();
    bus.start = 1'b0;
    #1;
    chk("post_rst_rel", bus.reljump_en, 1);
    chk("post_rst_lutclr", bus.target, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
